// File: rtl/noc_arq_rx.sv
// noc_arq_rx: ARQ receive stage. Checks the sequence number of each incoming
// NoC packet, forwards in-order packets unchanged, discards duplicates and
// out-of-order packets, and emits one cumulative ACK flit per completed packet.
//
// Optional build macro: NOC_ARQ_RX_STATS_EN
//   defined   -> saturating 16-bit forwarded/dropped packet counters
//   undefined -> stat_fwd_o / stat_drop_o tied to 0
//
// Handshake: a flit moves on a port in a cycle where its wrreq is high and the
// matching stall is low; wrreq/header/payload hold while stalled.
module noc_arq_rx #(
   parameter int NOC_HEADER_SIZE  = 16,
   parameter int NOC_PAYLOAD_SIZE = 32,
   parameter int NOC_MODE_SIZE    = 4,
   parameter logic [NOC_MODE_SIZE-1:0] MODE_ARQ_ACK = {NOC_MODE_SIZE{1'b1}},
   parameter int SEQ_WIDTH        = 4
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic                        wrreq_i,
   input  logic [NOC_HEADER_SIZE-1:0]  header_i,
   input  logic [NOC_PAYLOAD_SIZE-1:0] payload_i,
   output logic                        stall_o,
   output logic                        wrreq_o,
   output logic [NOC_HEADER_SIZE-1:0]  header_o,
   output logic [NOC_PAYLOAD_SIZE-1:0] payload_o,
   input  logic                        stall_i,
   input  logic [NOC_HEADER_SIZE-1:0]  ack_hdr_i,
   output logic                        ack_wrreq_o,
   output logic [NOC_HEADER_SIZE-1:0]  ack_header_o,
   output logic [NOC_PAYLOAD_SIZE-1:0] ack_payload_o,
   input  logic                        ack_stall_i,
   output logic [15:0]                 stat_fwd_o,
   output logic [15:0]                 stat_drop_o,
   output logic [1:0]                  state_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FWD  = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t                 r_state, state_nxt;
   logic [SEQ_WIDTH-1:0]   r_exp_seq;
   logic                   r_ack_valid;
   logic [SEQ_WIDTH-1:0]   r_ack_seq;

   logic [SEQ_WIDTH-1:0]   seq_in;
   logic                   burst_in;
   logic                   fwd_done;
   logic                   drop_done;
   logic [NOC_HEADER_SIZE-1:0] ack_hdr_clean;

   assign seq_in   = header_i[SEQ_WIDTH-1:0];
   assign burst_in = header_i[NOC_HEADER_SIZE-1];
   assign state_o  = r_state;

   // State register; a reset mid-packet restarts classification at IDLE.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) r_state <= IDLE;
      else         r_state <= state_nxt;
   end

   // Classify/forward flits and detect the packet-complete cycle.
   always_comb begin
      state_nxt = r_state;
      wrreq_o   = 1'b0;
      header_o  = '0;
      payload_o = '0;
      stall_o   = stall_i;
      fwd_done  = 1'b0;
      drop_done = 1'b0;
      case (r_state)
         IDLE: begin
            if (wrreq_i) begin
               if (seq_in == r_exp_seq) begin
                  wrreq_o   = 1'b1;
                  header_o  = header_i;
                  payload_o = payload_i;
                  if (!stall_i) begin
                     if (burst_in) state_nxt = FWD;
                     else          fwd_done  = 1'b1;
                  end
               end else begin
                  // Discarded flits are always absorbed, never stalled.
                  stall_o = 1'b0;
                  if (burst_in) state_nxt = DROP;
                  else          drop_done = 1'b1;
               end
            end
         end
         FWD: begin
            if (wrreq_i) begin
               wrreq_o   = 1'b1;
               header_o  = header_i;
               payload_o = payload_i;
               if (!stall_i && !burst_in) begin
                  state_nxt = IDLE;
                  fwd_done  = 1'b1;
               end
            end
         end
         DROP: begin
            stall_o = 1'b0;
            if (wrreq_i && !burst_in) begin
               state_nxt = IDLE;
               drop_done = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Expected sequence advances only when a forwarded packet completes.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)       r_exp_seq <= '0;
      else if (fwd_done) r_exp_seq <= r_exp_seq + SEQ_WIDTH'(1);
   end

   // Single-entry cumulative ACK slot: a reload overwrites a pending ACK and
   // wins over a same-cycle drain.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_ack_valid <= 1'b0;
         r_ack_seq   <= '0;
      end else if (fwd_done) begin
         r_ack_valid <= 1'b1;
         r_ack_seq   <= r_exp_seq;
      end else if (drop_done) begin
         r_ack_valid <= 1'b1;
         r_ack_seq   <= r_exp_seq - SEQ_WIDTH'(1);
      end else if (!ack_stall_i) begin
         r_ack_valid <= 1'b0;
      end
   end

   // ACK flit: static return header with the burst bit cleared.
   always_comb begin
      ack_hdr_clean = ack_hdr_i;
      ack_hdr_clean[NOC_HEADER_SIZE-1] = 1'b0;
      ack_wrreq_o   = r_ack_valid;
      ack_header_o  = '0;
      ack_payload_o = '0;
      if (r_ack_valid) begin
         ack_header_o = ack_hdr_clean;
         ack_payload_o[NOC_PAYLOAD_SIZE-1 -: NOC_MODE_SIZE] = MODE_ARQ_ACK;
         ack_payload_o[SEQ_WIDTH-1:0] = r_ack_seq;
      end
   end

`ifdef NOC_ARQ_RX_STATS_EN
   logic [15:0] r_stat_fwd, r_stat_drop;

   // Saturating packet counters, stepped on the packet-complete cycle.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_stat_fwd  <= '0;
         r_stat_drop <= '0;
      end else begin
         if (fwd_done && r_stat_fwd != 16'hFFFF)   r_stat_fwd  <= r_stat_fwd + 16'd1;
         if (drop_done && r_stat_drop != 16'hFFFF) r_stat_drop <= r_stat_drop + 16'd1;
      end
   end

   assign stat_fwd_o  = r_stat_fwd;
   assign stat_drop_o = r_stat_drop;
`else
   assign stat_fwd_o  = '0;
   assign stat_drop_o = '0;
`endif

endmodule

// File: tb/tb_noc_arq_rx.sv
// tb_noc_arq_rx: directed bench for noc_arq_rx. Honours NOC_ARQ_RX_STATS_EN
// when expecting the stat counters.
module tb_noc_arq_rx;
   localparam int H = 16;
   localparam int P = 32;
   localparam int M = 4;
   localparam int SW = 4;
   localparam int SMOD = 16;
   localparam logic [M-1:0] MODE = 4'h9;
`ifdef NOC_ARQ_RX_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   logic          clk;
   logic          reset_i;
   logic          wrreq_i;
   logic [H-1:0]  header_i;
   logic [P-1:0]  payload_i;
   logic          stall_o;
   logic          wrreq_o;
   logic [H-1:0]  header_o;
   logic [P-1:0]  payload_o;
   logic          stall_i;
   logic [H-1:0]  ack_hdr_i;
   logic          ack_wrreq_o;
   logic [H-1:0]  ack_header_o;
   logic [P-1:0]  ack_payload_o;
   logic          ack_stall_i;
   logic [15:0]   stat_fwd_o;
   logic [15:0]   stat_drop_o;
   logic [1:0]    state_o;

   int tests = 0;
   int fails = 0;
   logic [P-1:0]  fwd_q[$];
   logic [SW-1:0] ack_q[$];

   noc_arq_rx #(
      .NOC_HEADER_SIZE(H), .NOC_PAYLOAD_SIZE(P), .NOC_MODE_SIZE(M),
      .MODE_ARQ_ACK(MODE), .SEQ_WIDTH(SW)
   ) dut (
      .clk_i(clk), .reset_i(reset_i),
      .wrreq_i(wrreq_i), .header_i(header_i), .payload_i(payload_i),
      .stall_o(stall_o),
      .wrreq_o(wrreq_o), .header_o(header_o), .payload_o(payload_o),
      .stall_i(stall_i), .ack_hdr_i(ack_hdr_i),
      .ack_wrreq_o(ack_wrreq_o), .ack_header_o(ack_header_o),
      .ack_payload_o(ack_payload_o), .ack_stall_i(ack_stall_i),
      .stat_fwd_o(stat_fwd_o), .stat_drop_o(stat_drop_o), .state_o(state_o)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // driver tasks
   task automatic put(input logic w, input logic [SW-1:0] s, input logic b,
                      input logic [P-1:0] pl, input logic st, input logic ast);
      wrreq_i     = w;
      header_i    = {b, 11'h0A5, s};
      payload_i   = pl;
      stall_i     = st;
      ack_stall_i = ast;
      #2;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic ast);
      put(1'b0, 4'd0, 1'b0, 32'd0, 1'b0, ast);
      step();
   endtask

   // Behavioural model + scoreboards, checked at every falling edge.
   initial begin : model
      int m_exp, m_pk, m_ack_v, m_ack_seq, m_fwd_n, m_drop_n;
      int seq;
      logic b, e_fwd, e_drop, e_stall, pass, acc, last;
      logic [H-1:0] e_ahdr;
      logic [P-1:0] e_apl;
      m_exp = 0; m_pk = 0; m_ack_v = 0; m_ack_seq = 0; m_fwd_n = 0; m_drop_n = 0;
      forever begin
         @(negedge clk);
         if (reset_i) begin
            m_exp = 0; m_pk = 0; m_ack_v = 0; m_ack_seq = 0; m_fwd_n = 0; m_drop_n = 0;
         end
         seq     = int'(header_i[SW-1:0]);
         b       = header_i[H-1];
         // m_pk: 0 between packets, 1 inside a kept packet, 2 inside a discarded one
         e_fwd   = (m_pk == 1) || (m_pk == 0 && wrreq_i && seq == m_exp);
         e_drop  = (m_pk == 2) || (m_pk == 0 && wrreq_i && seq != m_exp);
         e_stall = e_drop ? 1'b0 : stall_i;
         pass    = e_fwd && wrreq_i;
         e_ahdr  = '0;
         e_apl   = '0;
         if (m_ack_v != 0) begin
            e_ahdr = ack_hdr_i & 16'h7FFF;
            e_apl  = (P'(MODE) << (P - M)) | P'(m_ack_seq);
         end
         chk("wrreq_o", wrreq_o, pass);
         chk("stall_o", stall_o, e_stall);
         chk("header_o", header_o, pass ? header_i : 16'd0);
         chk("payload_o", payload_o, pass ? payload_i : 32'd0);
         chk("ack_wrreq_o", ack_wrreq_o, m_ack_v != 0);
         chk("ack_header_o", ack_header_o, e_ahdr);
         chk("ack_payload_o", ack_payload_o, e_apl);
         chk("stat_fwd_o", stat_fwd_o, STATS != 0 ? m_fwd_n : 0);
         chk("stat_drop_o", stat_drop_o, STATS != 0 ? m_drop_n : 0);
         if (wrreq_o && !stall_i) begin
            if (fwd_q.size() == 0) chk("fwd_unexpected", payload_o, 32'hDEAD_BEEF);
            else chk("fwd_data", payload_o, fwd_q.pop_front());
         end
         if (ack_wrreq_o && !ack_stall_i) begin
            if (ack_q.size() == 0) chk("ack_unexpected", ack_payload_o[SW-1:0], 64'hFFFF);
            else chk("ack_seq", ack_payload_o[SW-1:0], ack_q.pop_front());
         end
         if (!reset_i) begin
            acc  = wrreq_i && !e_stall;
            last = acc && !b;
            if (last && e_fwd) begin
               m_ack_v = 1; m_ack_seq = m_exp; m_exp = (m_exp + 1) % SMOD;
               if (m_fwd_n < 65535) m_fwd_n++;
            end else if (last && e_drop) begin
               m_ack_v = 1; m_ack_seq = (m_exp + SMOD - 1) % SMOD;
               if (m_drop_n < 65535) m_drop_n++;
            end else if (!ack_stall_i) begin
               m_ack_v = 0;
            end
            if (acc && b) m_pk = e_fwd ? 1 : 2;
            if (last) m_pk = 0;
         end
      end
   end

   // directed stimulus
   initial begin
      reset_i = 1'b1;
      ack_hdr_i = 16'hC3F2;
      put(1'b0, 4'd0, 1'b0, 32'd0, 1'b1, 1'b0);
      step();
      put(1'b0, 4'd0, 1'b0, 32'd0, 1'b1, 1'b0);
      chk("rst_stall_follows", stall_o, 1);
      chk("rst_ack_wrreq", ack_wrreq_o, 0);
      chk("rst_wrreq", wrreq_o, 0);
      step();
      reset_i = 1'b0;

      // T1: single flit seq 0
      fwd_q.push_back(32'h1000_0000); ack_q.push_back(4'd0);
      put(1'b1, 4'd0, 1'b0, 32'h1000_0000, 1'b0, 1'b0);
      chk("t1_same_cycle_fwd", wrreq_o, 1);
      step();
      put(1'b0, 4'd0, 1'b0, 32'd0, 1'b0, 1'b0);
      chk("t1_ack_next_cycle", ack_wrreq_o, 1);
      chk("t1_ack_seq", ack_payload_o[SW-1:0], 0);
      step();

      // T2: 3-flit burst seq 1, flit 2 stalled for 2 cycles
      fwd_q.push_back(32'h2000_0001); fwd_q.push_back(32'h2000_0002);
      fwd_q.push_back(32'h2000_0003); ack_q.push_back(4'd1);
      put(1'b1, 4'd1, 1'b1, 32'h2000_0001, 1'b0, 1'b0); step();
      put(1'b1, 4'd1, 1'b1, 32'h2000_0002, 1'b1, 1'b0);
      chk("t2_stall_prop", stall_o, 1);
      step();
      put(1'b1, 4'd1, 1'b1, 32'h2000_0002, 1'b1, 1'b0); step();
      put(1'b1, 4'd1, 1'b1, 32'h2000_0002, 1'b0, 1'b0); step();
      put(1'b1, 4'd7, 1'b0, 32'h2000_0003, 1'b0, 1'b0); step();
      idle(1'b0);

      // T3: duplicate 2-flit burst seq 0 (exp = 2), stall_i high but ignored
      ack_q.push_back(4'd1);
      put(1'b1, 4'd0, 1'b1, 32'h3000_0001, 1'b1, 1'b0);
      chk("t3_no_stall", stall_o, 0);
      chk("t3_no_fwd", wrreq_o, 0);
      step();
      put(1'b1, 4'd0, 1'b0, 32'h3000_0002, 1'b1, 1'b0); step();
      idle(1'b0);
      chk("t3_stat_drop", stat_drop_o, STATS != 0 ? 1 : 0);

      // T4: ACK path stalled across two completions
      fwd_q.push_back(32'h4000_0002); fwd_q.push_back(32'h4000_0003);
      ack_q.push_back(4'd3);
      put(1'b1, 4'd2, 1'b0, 32'h4000_0002, 1'b0, 1'b1); step();
      put(1'b1, 4'd3, 1'b0, 32'h4000_0003, 1'b0, 1'b1); step();
      put(1'b0, 4'd0, 1'b0, 32'd0, 1'b0, 1'b1);
      chk("t4_pending", ack_wrreq_o, 1);
      chk("t4_pending_seq", ack_payload_o[SW-1:0], 3);
      step();
      idle(1'b0);
      put(1'b0, 4'd0, 1'b0, 32'd0, 1'b0, 1'b0);
      chk("t4_single_ack", ack_wrreq_o, 0);
      step();

      // T5: restart, stream 0..15, 0, then 1
      reset_i = 1'b1; idle(1'b0); reset_i = 1'b0;
      for (int i = 0; i < 18; i++) begin
         fwd_q.push_back(32'h5000_0000 + 32'(i));
         ack_q.push_back(4'(i % SMOD));
         put(1'b1, 4'(i % SMOD), 1'b0, 32'h5000_0000 + 32'(i), 1'b0, 1'b0);
         step();
      end
      idle(1'b0);
      chk("t5_stat_fwd", stat_fwd_o, STATS != 0 ? 18 : 0);

      // T6: async reset mid-burst (exp = 2)
      fwd_q.push_back(32'h6000_0001);
      put(1'b1, 4'd2, 1'b1, 32'h6000_0001, 1'b0, 1'b0); step();
      put(1'b1, 4'd5, 1'b1, 32'h6000_0002, 1'b1, 1'b0);
      chk("t6_pre_reset_stall", stall_o, 1);
      reset_i = 1'b1;
      #1;
      chk("t6_async_stall", stall_o, 0);
      chk("t6_async_wrreq", wrreq_o, 0);
      step();
      reset_i = 1'b0;
      ack_q.push_back(4'd15);
      put(1'b1, 4'd5, 1'b1, 32'h6000_0002, 1'b0, 1'b0); step();
      put(1'b1, 4'd5, 1'b0, 32'h6000_0003, 1'b0, 1'b0); step();
      put(1'b0, 4'd0, 1'b0, 32'd0, 1'b0, 1'b0);
      chk("t6_ack_wrap_back", ack_payload_o[SW-1:0], 15);
      step();
      idle(1'b0);
      idle(1'b0);

      chk("fwd_q_drained", 64'(fwd_q.size()), 0);
      chk("ack_q_drained", 64'(ack_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/noc_arq_rx.md
# noc_arq_rx

ARQ receive stage sitting directly downstream of the ARQ 1-to-2 demux's data output (non-ACK traffic). It checks the sequence number of each incoming NoC packet (single flit or burst) and forwards in-order packets unchanged. Duplicate or out-of-order packets are discarded. For every completed packet it generates a cumulative ACK flit that feeds the high-priority ACK input of the ARQ 2-to-1 mux.

## Interface

**Parameters**
- `NOC_HEADER_SIZE`, `NOC_PAYLOAD_SIZE`, `NOC_MODE_SIZE`, `MODE_ARQ_ACK`: from `noc_parameter.vh`.
- `SEQ_WIDTH`, default 4: sequence number width; the number is carried in `header_i[SEQ_WIDTH-1:0]`.

**Ports**
- `clk_i` in 1: single clock.
- `reset_i` in 1: asynchronous, active-high reset.
- `wrreq_i` in 1: input flit valid.
- `header_i` in `NOC_HEADER_SIZE`: input header; MSB is the burst bit (1 = more flits follow).
- `payload_i` in `NOC_PAYLOAD_SIZE`: input payload.
- `stall_o` out 1: back-pressure to the demux.
- `wrreq_o` / `header_o` / `payload_o` out 1 / H / P: forwarded in-order flits.
- `stall_i` in 1: downstream back-pressure.
- `ack_hdr_i` in `NOC_HEADER_SIZE`: static header for ACK flits (route back to sender); its burst bit is ignored and forced to 0.
- `ack_wrreq_o` / `ack_header_o` / `ack_payload_o` out 1 / H / P: ACK flit towards the 2-to-1 mux input 1.
- `ack_stall_i` in 1: ACK back-pressure.
- `stat_fwd_o` out 16: forwarded-packet counter (see Configuration).
- `stat_drop_o` out 16: dropped-packet counter (see Configuration).

## Operation

**Flit acceptance**
- A flit is accepted when `wrreq_i && !stall_o`.
- The last flit of a packet is an accepted flit with burst bit 0.

**Registers**
- `r_state` ∈ {IDLE, FWD, DROP}.
- `r_exp_seq` (`SEQ_WIDTH` bits): expected sequence number.
- `r_ack_valid`, `r_ack_seq`: single-entry ACK slot.

**IDLE** (packet boundary). The first flit is classified combinationally from `header_i[SEQ_WIDTH-1:0]`:
- seq == `r_exp_seq`: forward this flit; `wrreq_o=wrreq_i`, header/payload pass through, `stall_o=stall_i`.
  - Accepted with burst=1 → FWD.
  - Accepted with burst=0 → packet complete.
- seq ≠ `r_exp_seq`: discard; `wrreq_o=0`, `stall_o=0`.
  - burst=1 → DROP.
  - burst=0 → packet complete.

**FWD**
- Pass-through as above; sequence bits of continuation flits are ignored.
- Last accepted flit → IDLE.

**DROP**
- `stall_o=0`, `wrreq_o=0`, flits absorbed.
- Last accepted flit → IDLE.

**Packet complete (forwarded)**
- `r_exp_seq <= r_exp_seq+1`, mod 2^`SEQ_WIDTH` (wrap from all-ones to 0).
- Load ACK slot with the received seq.

**Packet complete (dropped)**
- Load ACK slot with `r_exp_seq-1` mod 2^`SEQ_WIDTH` (re-ACK of last good packet).

**ACK output**
- `ack_wrreq_o=r_ack_valid`.
- `ack_header_o=ack_hdr_i` with MSB=0.
- `ack_payload_o={MODE_ARQ_ACK, zeros, r_ack_seq}`.
- The slot clears when `!ack_stall_i`, unless it is reloaded in the same cycle.

**Cumulative ACK overwrite**
- A new ACK overwrites a still-pending one. ACKs are cumulative, so the input is never stalled because of the ACK path.

**Idle outputs**
- When not forwarding, `header_o`/`payload_o` are 0.
- `stall_o=stall_i` in IDLE without `wrreq_i`.

## Timing

**Reset values**
- `r_state`=IDLE, `r_exp_seq`=0, `r_ack_valid`=0, `r_ack_seq`=0.
- All outputs 0, except `stall_o=stall_i`.
- Stat counters are 0.

**Latency**
- Data path: 0 cycles (combinational).
- ACK appears on `ack_wrreq_o` the cycle after the last flit is accepted.
- ACK slot loaded and drained in the same cycle: the new value wins and `ack_wrreq_o` stays 1.
- A stalled flit (`stall_i=1` in IDLE/FWD) is not accepted; state, sequence and ACK slot hold.

**Reset mid-packet**
- Return to IDLE with `r_exp_seq=0`.
- Remaining flits of the interrupted packet are classified as a new first flit.

**Counter behaviour**
- Stat counters saturate at 0xFFFF.

## Configuration

`NOC_ARQ_RX_STATS_EN`
- Defined: `stat_fwd_o` increments per forwarded packet and `stat_drop_o` per dropped packet, at the packet-complete cycle, saturating.
- Undefined: no counter registers; both outputs tied to 0.

## Test plan

1. Reset, then single-flit packet seq=0, `stall_i=0`:
   - `wrreq_o` high the same cycle.
   - `r_exp_seq`=1.
   - Next cycle `ack_wrreq_o=1`, ACK seq=0.
2. 3-flit burst seq=1 with `stall_i=1` on flit 2 for 2 cycles:
   - All 3 flits forwarded in order and the stall is propagated to `stall_o`.
   - One ACK seq=1 after flit 3.
3. Duplicate 2-flit burst seq=0 after exp=2:
   - `wrreq_o` stays 0 and `stall_o`=0.
   - ACK seq=1.
   - `stat_drop_o`=1 with the macro defined, 0 without.
4. `ack_stall_i=1` held while packets seq=2 and seq=3 complete:
   - Single pending ACK, showing seq=3.
   - Released → exactly one ACK flit.
5. Wrap: `SEQ_WIDTH`=4, stream packets 0..15 then 0:
   - All forwarded.
   - ACKs 15 then 0.
   - A packet with seq=1 arriving while exp=1 after the wrap is accepted.
6. Assert `reset_i` during FWD mid-burst:
   - Outputs drop to reset values asynchronously.
   - Next flit with seq≠0 is dropped; its packet end gives ACK seq=15.
